// File: rtl/rx_iq_fifo_if.sv
// rtl/rx_iq_fifo_if.sv - sample-pair write side, show-ahead read side and status of the rx IQ FIFO
interface rx_iq_fifo_if #(
    parameter int CNT_W = 11
);
    logic             iq_valid;
    logic [23:0]      i_data;
    logic [23:0]      q_data;
    logic [23:0]      rx_data;
    logic             rx_request;
    logic [CNT_W-1:0] rx_length;
    logic             overflow;
    logic             underflow;
    logic [15:0]      drop_count;

    modport master (
        output iq_valid, i_data, q_data, rx_request,
        input  rx_data, rx_length, overflow, underflow, drop_count
    );

    modport slave (
        input  iq_valid, i_data, q_data, rx_request,
        output rx_data, rx_length, overflow, underflow, drop_count
    );
endinterface

// File: rtl/rx_iq_fifo.sv
// rtl/rx_iq_fifo.sv - pair-atomic I/Q staging into a single-clock show-ahead FIFO for the rx packetiser
module rx_iq_fifo #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    rx_iq_fifo_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] PAIR_LIMIT = CNT_W'(DEPTH - 2);

    typedef enum logic {
        IDLE,
        WRITE_Q
    } state_t;

    state_t            state;
    logic              armed;
    logic [23:0]       q_hold;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              ovf_flag;
    logic              udf_flag;
    logic [15:0]       drops;
    logic [23:0]       mem [DEPTH];

    logic              wr_en;
    logic [23:0]       wr_data;
    logic              pair_ok;
    logic              pair_drop;
    logic              pop_ok;
    logic              pop_empty;

    // armed stays low for the first edge after reset release so nothing acts on it
    always_comb begin
        wr_en     = 1'b0;
        wr_data   = bus.i_data;
        pair_ok   = 1'b0;
        pair_drop = 1'b0;
        pop_ok    = 1'b0;
        pop_empty = 1'b0;
        if (armed && !flush) begin
            if (state == IDLE) begin
                if (bus.iq_valid) begin
                    if (count <= PAIR_LIMIT) begin
                        wr_en   = 1'b1;
                        pair_ok = 1'b1;
                    end else begin
                        pair_drop = 1'b1;
                    end
                end
            end else begin
                wr_en   = 1'b1;
                wr_data = q_hold;
                if (bus.iq_valid) begin
                    pair_drop = 1'b1;
                end
            end
            if (bus.rx_request) begin
                if (count != '0) begin
                    pop_ok = 1'b1;
                end else begin
                    pop_empty = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed    <= 1'b0;
            state    <= IDLE;
            q_hold   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
            udf_flag <= 1'b0;
            drops    <= '0;
        end else begin
            armed <= 1'b1;
            if (flush) begin
                state    <= IDLE;
                q_hold   <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                ovf_flag <= 1'b0;
                udf_flag <= 1'b0;
                drops    <= '0;
            end else begin
                state <= pair_ok ? WRITE_Q : IDLE;
                if (pair_ok) begin
                    q_hold <= bus.q_data;
                end
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + {{(CNT_W-1){1'b0}}, wr_en} - {{(CNT_W-1){1'b0}}, pop_ok};
                if (pair_drop) begin
                    ovf_flag <= 1'b1;
                    if (drops != 16'hFFFF) begin
                        drops <= drops + 16'd1;
                    end
                end
                if (pop_empty) begin
                    udf_flag <= 1'b1;
                end
            end
        end
    end

    // storage has no reset; the empty check below masks stale contents
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign bus.rx_data    = (count == '0) ? 24'd0 : mem[rd_ptr];
    assign bus.rx_length  = count;
    assign bus.overflow   = ovf_flag;
    assign bus.underflow  = udf_flag;
    assign bus.drop_count = drops;
endmodule
